// File: rtl/serial_pair_src.sv
// Bit-serial two-line stimulus source: shifts an accepted operand pair out LSB-first
// and drives the golden serial sum bit and final carry alongside the lines.
module serial_pair_src #(
  parameter int W   = 8,
  parameter int GAP = 1
) (
  input  logic         CK,
  input  logic         RST,
  input  logic         LOAD_VALID,
  output logic         LOAD_READY,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         LINE1,
  output logic         LINE2,
  output logic         FRAME,
  output logic         LAST,
  output logic         EXP_OUT,
  output logic         EXP_OVF,
  output logic         DONE
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  localparam int               CNT_W    = (W > 1) ? $clog2(W) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(W - 1);
  localparam logic [3:0]       GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  state_t           state, state_nx;
  logic             armed;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [3:0]       gcnt, gcnt_nx;
  logic             carry, carry_nx;
  logic [W-1:0]     sa, sa_nx, sb, sb_nx;
  logic             line1_nx, line2_nx, frame_nx, last_nx, out_nx, ovf_nx, done_nx;

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  function automatic logic sum3(input logic x, input logic y, input logic z);
    return x ^ y ^ z;
  endfunction

  // armed stays low through reset so the block never looks ready while RST is held
  assign LOAD_READY = armed && (state == S_IDLE);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    gcnt_nx  = gcnt;
    carry_nx = carry;
    sa_nx    = sa;
    sb_nx    = sb;
    line1_nx = 1'b0;
    line2_nx = 1'b0;
    frame_nx = 1'b0;
    last_nx  = 1'b0;
    out_nx   = 1'b0;
    ovf_nx   = 1'b0;
    done_nx  = 1'b0;
    case (state)
      S_IDLE: begin
        if (LOAD_VALID && LOAD_READY) begin
          // bit 0 goes out on the accept edge itself, with carry-in 0
          line1_nx = A[0];
          line2_nx = B[0];
          frame_nx = 1'b1;
          out_nx   = sum3(A[0], B[0], 1'b0);
          carry_nx = maj3(A[0], B[0], 1'b0);
          sa_nx    = A >> 1;
          sb_nx    = B >> 1;
          cnt_nx   = '0;
          state_nx = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (cnt == BIT_LAST) begin
          done_nx  = 1'b1;
          ovf_nx   = carry;
          gcnt_nx  = '0;
          state_nx = (GAP > 0) ? S_GAP : S_IDLE;
        end else begin
          line1_nx = sa[0];
          line2_nx = sb[0];
          frame_nx = 1'b1;
          out_nx   = sum3(sa[0], sb[0], carry);
          carry_nx = maj3(sa[0], sb[0], carry);
          sa_nx    = sa >> 1;
          sb_nx    = sb >> 1;
          cnt_nx   = cnt + CNT_W'(1);
          last_nx  = (cnt_nx == BIT_LAST);
        end
      end
      S_GAP: begin
        if (gcnt == GAP_LAST) state_nx = S_IDLE;
        else                  gcnt_nx  = gcnt + 4'd1;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state   <= S_IDLE;
      armed   <= 1'b0;
      cnt     <= '0;
      gcnt    <= '0;
      carry   <= 1'b0;
      LINE1   <= 1'b0;
      LINE2   <= 1'b0;
      FRAME   <= 1'b0;
      LAST    <= 1'b0;
      EXP_OUT <= 1'b0;
      EXP_OVF <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      state   <= state_nx;
      armed   <= 1'b1;
      cnt     <= cnt_nx;
      gcnt    <= gcnt_nx;
      carry   <= carry_nx;
      LINE1   <= line1_nx;
      LINE2   <= line2_nx;
      FRAME   <= frame_nx;
      LAST    <= last_nx;
      EXP_OUT <= out_nx;
      EXP_OVF <= ovf_nx;
      DONE    <= done_nx;
    end
  end

  always_ff @(posedge CK) begin
    sa <= sa_nx;
    sb <= sb_nx;
  end

endmodule
